// File: rtl/lcd_text_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_text_writer_if
// Purpose  : Requester, clear-control and character-RAM write signals.
// Revision : 1.0  initial release
// ============================================================================
interface lcd_text_writer_if;
  logic       a_req;
  logic [6:0] a_column;
  logic [5:0] a_row;
  logic [6:0] a_character;
  logic       a_ack;

  logic       b_req;
  logic [6:0] b_column;
  logic [5:0] b_row;
  logic [6:0] b_character;
  logic       b_ack;

  logic        clear_req;
  logic        clear_busy;
  logic        ram_we;
  logic [12:0] ram_address;
  logic [6:0]  ram_data;

  modport master (
    output a_req, a_column, a_row, a_character,
    output b_req, b_column, b_row, b_character,
    output clear_req,
    input  a_ack, b_ack, clear_busy, ram_we, ram_address, ram_data
  );

  modport slave (
    input  a_req, a_column, a_row, a_character,
    input  b_req, b_column, b_row, b_character,
    input  clear_req,
    output a_ack, b_ack, clear_busy, ram_we, ram_address, ram_data
  );
endinterface
`default_nettype wire

// File: rtl/lcd_text_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_text_writer
// Purpose  : Two-requester character-RAM writer with round-robin arbitration
//            and a row-major full-screen clear engine.
// Revision : 1.0  initial release
// ============================================================================
module lcd_text_writer #(
  parameter int         COLUMNS    = 80,
  parameter int         ROWS       = 30,
  parameter logic [6:0] CLEAR_CHAR = 7'h20
) (
  input  logic              clock,
  input  logic              reset_n,
  lcd_text_writer_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [7:0] COLUMNS_W   = 8'(COLUMNS);
  localparam logic [6:0] ROWS_W      = 7'(ROWS);
  localparam logic [6:0] LAST_COLUMN = 7'(COLUMNS - 1);
  localparam logic [5:0] LAST_ROW    = 6'(ROWS - 1);

  state_t      state_q, state_d;
  logic        ram_we_q, ram_we_d;
  logic [12:0] ram_address_q, ram_address_d;
  logic [6:0]  ram_data_q, ram_data_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        clear_busy_q, clear_busy_d;
  logic        prefer_b_q, prefer_b_d;
  logic [6:0]  column_q, column_d;
  logic [5:0]  row_q, row_d;

  logic       a_eligible, b_eligible;
  logic       a_in_range, b_in_range;
  logic       grant_a, grant_b;
  logic       last_cell;
  logic [6:0] column_next;
  logic [5:0] row_next;

  // A requester whose ack is on this cycle is finishing, not asking again.
  assign a_eligible = bus.a_req & ~a_ack_q;
  assign b_eligible = bus.b_req & ~b_ack_q;

  assign a_in_range = ({1'b0, bus.a_column} < COLUMNS_W) && ({1'b0, bus.a_row} < ROWS_W);
  assign b_in_range = ({1'b0, bus.b_column} < COLUMNS_W) && ({1'b0, bus.b_row} < ROWS_W);

  assign grant_a = (state_q == IDLE) && !bus.clear_req && a_eligible
                   && (!b_eligible || !prefer_b_q);
  assign grant_b = (state_q == IDLE) && !bus.clear_req && b_eligible
                   && (!a_eligible || prefer_b_q);

  assign last_cell = (column_q == LAST_COLUMN) && (row_q == LAST_ROW);

  always_comb begin
    column_next = column_q + 7'd1;
    row_next    = row_q;
    if (column_q == LAST_COLUMN) begin
      column_next = 7'd0;
      row_next    = row_q + 6'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    ram_we_d      = 1'b0;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    a_ack_d       = 1'b0;
    b_ack_d       = 1'b0;
    clear_busy_d  = 1'b0;
    prefer_b_d    = prefer_b_q;
    column_d      = column_q;
    row_d         = row_q;

    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d       = CLEAR;
          ram_we_d      = 1'b1;
          clear_busy_d  = 1'b1;
          ram_address_d = 13'd0;
          ram_data_d    = CLEAR_CHAR;
          column_d      = 7'd0;
          row_d         = 6'd0;
        end else if (grant_a) begin
          a_ack_d    = 1'b1;
          prefer_b_d = 1'b1;
          if (a_in_range) begin
            ram_we_d      = 1'b1;
            ram_address_d = {bus.a_row, bus.a_column};
            ram_data_d    = bus.a_character;
          end
        end else if (grant_b) begin
          b_ack_d    = 1'b1;
          prefer_b_d = 1'b0;
          if (b_in_range) begin
            ram_we_d      = 1'b1;
            ram_address_d = {bus.b_row, bus.b_column};
            ram_data_d    = bus.b_character;
          end
        end
      end

      CLEAR: begin
        // column_q/row_q name the cell whose write is on the outputs now.
        if (last_cell) begin
          state_d  = IDLE;
          column_d = 7'd0;
          row_d    = 6'd0;
        end else begin
          column_d      = column_next;
          row_d         = row_next;
          ram_we_d      = 1'b1;
          clear_busy_d  = 1'b1;
          ram_address_d = {row_next, column_next};
          ram_data_d    = CLEAR_CHAR;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ram_we_q      <= 1'b0;
      ram_address_q <= 13'd0;
      ram_data_q    <= 7'd0;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      clear_busy_q  <= 1'b0;
      prefer_b_q    <= 1'b0;
      column_q      <= 7'd0;
      row_q         <= 6'd0;
    end else begin
      state_q       <= state_d;
      ram_we_q      <= ram_we_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      a_ack_q       <= a_ack_d;
      b_ack_q       <= b_ack_d;
      clear_busy_q  <= clear_busy_d;
      prefer_b_q    <= prefer_b_d;
      column_q      <= column_d;
      row_q         <= row_d;
    end
  end

  assign bus.ram_we      = ram_we_q;
  assign bus.ram_address = ram_address_q;
  assign bus.ram_data    = ram_data_q;
  assign bus.a_ack       = a_ack_q;
  assign bus.b_ack       = b_ack_q;
  assign bus.clear_busy  = clear_busy_q;

endmodule
`default_nettype wire
